// File: rtl/dcache_store_port.sv
// dcache_store_port
//
// Store port of the data cache. Committed stores from the store buffer are
// queued in a small FIFO and drained one at a time toward the memory side.
// Loads can probe the queue for a word-address hazard.
//
// Parameters
//   DEPTH        number of store-queue entries (power of two, 2..16)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   store_req    committed-store request
//   store_wstrb  byte strobes of the request
//   store_size   access size of the request
//   store_addr   store address
//   store_data   store data
//   addr_ok      queue can take a request this cycle (not full)
//   data_ok      one-cycle completion pulse, the cycle after each acceptance
//   lookup_addr  load address to check against queued stores
//   lookup_hit   some queued store matches lookup_addr[31:2]
//   wr_req       write request for the head entry
//   wr_wstrb     strobes of the head entry
//   wr_size      size of the head entry
//   wr_addr      address of the head entry
//   wr_data      data of the head entry
//   wr_rdy       memory side takes wr_req this cycle
//   wr_done      memory side finished the outstanding write
//   idle         queue empty and no write outstanding
module dcache_store_port #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        store_req,
    input  logic [3:0]  store_wstrb,
    input  logic [2:0]  store_size,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    output logic        addr_ok,
    output logic        data_ok,
    input  logic [31:0] lookup_addr,
    output logic        lookup_hit,
    output logic        wr_req,
    output logic [3:0]  wr_wstrb,
    output logic [2:0]  wr_size,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_rdy,
    input  logic        wr_done,
    output logic        idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = 71;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q, state_d;
    logic [PW:0]   head_q, head_d;
    logic [PW:0]   tail_q, tail_d;
    logic          data_ok_q, data_ok_d;
    logic [EW-1:0] ent_q [DEPTH];
    logic [EW-1:0] ent_d [DEPTH];

    logic          empty;
    logic          full;
    logic          accept;
    logic [PW:0]   count;
    logic [EW-1:0] head_ent;
    logic          lookup_addr_unused;

    // Entry layout: {wstrb[70:67], size[66:64], addr[63:32], data[31:0]}.
    // Pointers carry an extra wrap bit, so plain +1 toggles it at DEPTH-1.
    assign empty    = (head_q == tail_q);
    assign full     = (head_q[PW-1:0] == tail_q[PW-1:0]) && (head_q[PW] != tail_q[PW]);
    assign count    = tail_q - head_q;
    assign accept   = store_req && !full;
    assign head_ent = ent_q[head_q[PW-1:0]];

    assign addr_ok  = !full;
    assign data_ok  = data_ok_q;
    assign wr_req   = (state_q == IDLE) && !empty;
    assign wr_wstrb = head_ent[70:67];
    assign wr_size  = head_ent[66:64];
    assign wr_addr  = head_ent[63:32];
    assign wr_data  = head_ent[31:0];
    assign idle     = empty && (state_q == IDLE);

    // Hazard check is word granular, so the byte offset of the load is unused.
    assign lookup_addr_unused = ^lookup_addr[1:0];

    // An entry is occupied when its distance from the head is below the
    // occupancy. The head stays occupied while its write is outstanding, and
    // the entry being written this cycle is not counted until the tail moves.
    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - head_q[PW-1:0]} < count) &&
                (ent_q[i][63:34] == lookup_addr[31:2])) begin
                lookup_hit = 1'b1;
            end
        end
    end

    // Next-state logic: enqueue at the tail, drain the head through a
    // two-state handshake (request, then wait for completion).
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        data_ok_d = accept;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end

        if (accept) begin
            ent_d[tail_q[PW-1:0]] = {store_wstrb, store_size, store_addr, store_data};
            tail_d = tail_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (wr_req && wr_rdy) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (wr_done) begin
                    state_d = IDLE;
                    head_d  = head_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            data_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            data_ok_q <= data_ok_d;
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

endmodule

// File: tb/tb_dcache_store_port.sv
// tb_dcache_store_port
//
// Bench for dcache_store_port (DEPTH = 4). A short table of hand-computed
// vectors covers a single store and the load hazard, hand-written sequences
// cover fill/back-pressure, wrap-around and reset during a write, and a
// randomized run is compared every cycle against a queue-based model.
module tb_dcache_store_port;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        store_req;
    logic [3:0]  store_wstrb;
    logic [2:0]  store_size;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] lookup_addr;
    logic        lookup_hit;
    logic        wr_req;
    logic [3:0]  wr_wstrb;
    logic [2:0]  wr_size;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_rdy;
    logic        wr_done;
    logic        idle;

    int tests_run    = 0;
    int tests_failed = 0;

    // One cycle's inputs plus, for table rows, the expected outputs.
    typedef struct {
        logic        rst;
        logic        req;
        logic [3:0]  wstrb;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] lookup;
        logic        rdy;
        logic        done;
        logic        chk;
        logic        e_addr_ok;
        logic        e_data_ok;
        logic        e_wr_req;
        logic [31:0] e_wr_addr;
        logic        e_hit;
        logic        e_idle;
    } vec_t;

    // Reference model: the queue contents in order, whether the head write
    // is outstanding, and whether a completion pulse is due this cycle.
    typedef struct {
        logic [3:0]  wstrb;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    bit   mbusy       = 1'b0;
    bit   mdok        = 1'b0;
    bit   model_valid = 1'b0;

    vec_t tbl[$];

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    dcache_store_port #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .store_req   (store_req),
        .store_wstrb (store_wstrb),
        .store_size  (store_size),
        .store_addr  (store_addr),
        .store_data  (store_data),
        .addr_ok     (addr_ok),
        .data_ok     (data_ok),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .wr_req      (wr_req),
        .wr_wstrb    (wr_wstrb),
        .wr_size     (wr_size),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_rdy      (wr_rdy),
        .wr_done     (wr_done),
        .idle        (idle)
    );

    // Safety net in case something goes badly wrong with time advance.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t vin(logic rst, logic req, logic [3:0] wstrb, logic [2:0] size,
                                 logic [31:0] addr, logic [31:0] data, logic [31:0] lookup,
                                 logic rdy, logic done);
        vec_t v;
        v.rst = rst;  v.req = req;  v.wstrb = wstrb;  v.size = size;
        v.addr = addr;  v.data = data;  v.lookup = lookup;
        v.rdy = rdy;  v.done = done;
        v.chk = 1'b0;
        v.e_addr_ok = 1'b0;  v.e_data_ok = 1'b0;  v.e_wr_req = 1'b0;
        v.e_wr_addr = '0;  v.e_hit = 1'b0;  v.e_idle = 1'b0;
        return v;
    endfunction

    function automatic vec_t mkVec(logic req, logic [31:0] addr, logic [31:0] data,
                                   logic [31:0] lookup, logic rdy, logic done,
                                   logic e_addr_ok, logic e_data_ok, logic e_wr_req,
                                   logic [31:0] e_wr_addr, logic e_hit, logic e_idle);
        vec_t v;
        v = vin(1'b0, req, 4'hF, 3'd2, addr, data, lookup, rdy, done);
        v.chk = 1'b1;
        v.e_addr_ok = e_addr_ok;  v.e_data_ok = e_data_ok;  v.e_wr_req = e_wr_req;
        v.e_wr_addr = e_wr_addr;  v.e_hit = e_hit;  v.e_idle = e_idle;
        return v;
    endfunction

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs shortly after the rising edge and let the
    // combinational outputs settle before anything looks at them.
    task automatic applyStimulus(vec_t v);
        reset       = v.rst;
        store_req   = v.req;
        store_wstrb = v.wstrb;
        store_size  = v.size;
        store_addr  = v.addr;
        store_data  = v.data;
        lookup_addr = v.lookup;
        wr_rdy      = v.rdy;
        wr_done     = v.done;
        #1;
    endtask

    // Compare every output against the model for the current cycle.
    task automatic checkOutput();
        bit hit;
        if (!model_valid) return;
        checkVal("addr_ok", addr_ok, mq.size() < DEPTH);
        checkVal("data_ok", data_ok, mdok);
        checkVal("wr_req", wr_req, !mbusy && mq.size() > 0);
        checkVal("idle", idle, mq.size() == 0 && !mbusy);
        hit = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].addr[31:2] == lookup_addr[31:2]) hit = 1'b1;
        end
        checkVal("lookup_hit", lookup_hit, hit);
        if (mq.size() > 0) begin
            checkVal("wr_addr", wr_addr, mq[0].addr);
            checkVal("wr_data", wr_data, mq[0].data);
            checkVal("wr_wstrb", wr_wstrb, mq[0].wstrb);
            checkVal("wr_size", wr_size, mq[0].size);
        end
    endtask

    // Advance the model with the inputs that the coming edge will sample.
    task automatic modelAdvance();
        bit   acc;
        bit   deq;
        bit   start;
        ent_t e;
        if (reset) begin
            mq.delete();
            mbusy       = 1'b0;
            mdok        = 1'b0;
            model_valid = 1'b1;
        end else begin
            acc   = store_req && (mq.size() < DEPTH);
            deq   = mbusy && wr_done;
            start = !mbusy && (mq.size() > 0) && wr_rdy;
            if (deq) begin
                void'(mq.pop_front());
                mbusy = 1'b0;
            end else if (start) begin
                mbusy = 1'b1;
            end
            if (acc) begin
                e.wstrb = store_wstrb;  e.size = store_size;
                e.addr  = store_addr;   e.data = store_data;
                mq.push_back(e);
            end
            mdok = acc;
        end
    endtask

    task automatic tick();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(logic rdy, logic done);
        applyStimulus(vin(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 32'h0, 32'h0, rdy, done));
    endtask

    // Main sequence: table, hand-written corner cases, then random traffic.
    initial begin
        logic [31:0] seen[$];
        int          nxt;

        reset = 1'b0;  store_req = 1'b0;  store_wstrb = '0;  store_size = '0;
        store_addr = '0;  store_data = '0;  lookup_addr = '0;  wr_rdy = 1'b0;  wr_done = 1'b0;
        @(posedge clk);
        #1;

        // Table: reset state, single store, then the load-hazard sequence.
        tbl.push_back(vin(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        //                req  addr          data          lookup        rdy   done  aok   dok   wreq  wr_addr       hit   idle
        tbl.push_back(mkVec(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1));
        tbl.push_back(mkVec(1'b0, 32'h0,         32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0));
        tbl.push_back(mkVec(1'b0, 32'h0,         32'h0,         32'h0000_1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0));
        tbl.push_back(mkVec(1'b0, 32'h0,         32'h0,         32'h0000_1003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0));
        tbl.push_back(mkVec(1'b0, 32'h0,         32'h0,         32'h0000_1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1));
        tbl.push_back(mkVec(1'b1, 32'h0000_2004, 32'h0000_0011, 32'h0000_2004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1));
        tbl.push_back(mkVec(1'b0, 32'h0,         32'h0,         32'h0000_2006, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2004, 1'b1, 1'b0));
        tbl.push_back(mkVec(1'b0, 32'h0,         32'h0,         32'h0000_2008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2004, 1'b0, 1'b0));
        tbl.push_back(mkVec(1'b0, 32'h0,         32'h0,         32'h0000_2006, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2004, 1'b1, 1'b0));
        tbl.push_back(mkVec(1'b0, 32'h0,         32'h0,         32'h0000_2006, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0));
        tbl.push_back(mkVec(1'b0, 32'h0,         32'h0,         32'h0000_2006, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0));
        tbl.push_back(mkVec(1'b0, 32'h0,         32'h0,         32'h0000_2006, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1));

        foreach (tbl[k]) begin
            applyStimulus(tbl[k]);
            checkOutput();
            if (tbl[k].chk) begin
                checkVal($sformatf("tbl%0d addr_ok", k), addr_ok, tbl[k].e_addr_ok);
                checkVal($sformatf("tbl%0d data_ok", k), data_ok, tbl[k].e_data_ok);
                checkVal($sformatf("tbl%0d wr_req", k), wr_req, tbl[k].e_wr_req);
                checkVal($sformatf("tbl%0d lookup_hit", k), lookup_hit, tbl[k].e_hit);
                checkVal($sformatf("tbl%0d idle", k), idle, tbl[k].e_idle);
                if (tbl[k].e_wr_req) begin
                    checkVal($sformatf("tbl%0d wr_addr", k), wr_addr, tbl[k].e_wr_addr);
                end
            end
            tick();
        end

        // Fill: four stores fill the queue, a fifth waits for the first
        // completion and is taken only the cycle after it.
        applyStimulus(vin(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        tick();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(vin(1'b0, 1'b1, 4'h3, 3'd1, 32'h0000_5000 + 32'(c * 4), 32'(c + 100), 32'h0, 1'b0, 1'b0));
            checkOutput();
            checkVal($sformatf("fill%0d addr_ok", c), addr_ok, 1'b1);
            checkVal($sformatf("fill%0d data_ok", c), data_ok, c > 0);
            tick();
        end
        applyStimulus(vin(1'b0, 1'b1, 4'h3, 3'd1, 32'h0000_5010, 32'd104, 32'h0, 1'b0, 1'b0));
        checkOutput();
        checkVal("fill full addr_ok", addr_ok, 1'b0);
        checkVal("fill 4th data_ok", data_ok, 1'b1);
        tick();
        applyStimulus(vin(1'b0, 1'b1, 4'h3, 3'd1, 32'h0000_5010, 32'd104, 32'h0, 1'b1, 1'b0));
        checkOutput();
        checkVal("fill held addr_ok", addr_ok, 1'b0);
        checkVal("fill head wr_addr", wr_addr, 32'h0000_5000);
        tick();
        applyStimulus(vin(1'b0, 1'b1, 4'h3, 3'd1, 32'h0000_5010, 32'd104, 32'h0, 1'b0, 1'b1));
        checkOutput();
        checkVal("fill done-cycle addr_ok", addr_ok, 1'b0);
        tick();
        applyStimulus(vin(1'b0, 1'b1, 4'h3, 3'd1, 32'h0000_5010, 32'd104, 32'h0, 1'b0, 1'b0));
        checkOutput();
        checkVal("fill freed addr_ok", addr_ok, 1'b1);
        tick();
        quiet(1'b0, 1'b0);
        checkOutput();
        checkVal("fill 5th data_ok", data_ok, 1'b1);
        tick();
        for (int n = 0; n < 40 && !(mq.size() == 0 && !mbusy); n++) begin
            quiet(1'b1, 1'b1);
            checkOutput();
            tick();
        end
        quiet(1'b0, 1'b0);
        checkVal("fill drained idle", idle, 1'b1);

        // Wrap-around: ten stores drained with completion one cycle after
        // each handshake; the write order must equal the issue order.
        applyStimulus(vin(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        tick();
        nxt = 0;
        for (int cyc = 0; cyc < 100 && (seen.size() < 10 || mbusy || mq.size() > 0); cyc++) begin
            applyStimulus(vin(1'b0, nxt < 10, 4'hF, 3'd2, 32'h0000_6000 + 32'(nxt * 8),
                              32'hA000_0000 + 32'(nxt), 32'h0, 1'b1, mbusy));
            checkOutput();
            if (wr_req && wr_rdy) seen.push_back(wr_addr);
            if (store_req && mq.size() < DEPTH) nxt++;
            tick();
        end
        checkVal("wrap write count", seen.size(), 10);
        foreach (seen[i]) begin
            checkVal($sformatf("wrap order %0d", i), seen[i], 32'h0000_6000 + 32'(i * 8));
        end
        quiet(1'b0, 1'b0);
        checkVal("wrap final idle", idle, 1'b1);

        // Reset while a write is outstanding with three entries queued.
        applyStimulus(vin(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        tick();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(vin(1'b0, 1'b1, 4'h1, 3'd0, 32'h0000_7000 + 32'(c * 4), 32'(c), 32'h0, 1'b0, 1'b0));
            checkOutput();
            tick();
        end
        quiet(1'b1, 1'b0);
        checkOutput();
        tick();
        applyStimulus(vin(1'b1, 1'b1, 4'h1, 3'd0, 32'h0000_7100, 32'h0, 32'h0000_7000, 1'b0, 1'b0));
        checkOutput();
        checkVal("rst busy wr_req", wr_req, 1'b0);
        checkVal("rst busy idle", idle, 1'b0);
        tick();
        applyStimulus(vin(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 32'h0, 32'h0000_7000, 1'b1, 1'b1));
        checkOutput();
        checkVal("post-rst wr_req", wr_req, 1'b0);
        checkVal("post-rst idle", idle, 1'b1);
        checkVal("post-rst addr_ok", addr_ok, 1'b1);
        checkVal("post-rst data_ok", data_ok, 1'b0);
        checkVal("post-rst lookup_hit", lookup_hit, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            quiet(1'b1, 1'b1);
            checkOutput();
            checkVal("post-rst quiet wr_req", wr_req, 1'b0);
            checkVal("post-rst quiet data_ok", data_ok, 1'b0);
            tick();
        end

        // Random traffic against the model, including occasional resets and
        // stray completions while nothing is outstanding.
        applyStimulus(vin(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        tick();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            applyStimulus(vin($urandom_range(0, 99) == 0,
                              $urandom_range(0, 9) < 6,
                              4'($urandom),
                              3'($urandom_range(0, 2)),
                              32'h0000_3000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                              $urandom,
                              32'h0000_3000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                              $urandom_range(0, 1) == 1,
                              $urandom_range(0, 9) < 4));
            checkOutput();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
